// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, states, instruction
// classes and the ALU operand/operation select codes.
package multicycle_control_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        DECODE     = 3'd1,
        EXECUTE    = 3'd2,
        MEM_ACCESS = 3'd3,
        WRITEBACK  = 3'd4,
        HALT       = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_OP_IMM = 3'd5
    } instr_class_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } alu_src_b_t;

endpackage

// File: rtl/multicycle_control_opcode_class_decode.sv
// Combinational opcode -> instruction class / legal flag.
// I-type ALU opcodes are accepted only when MC_CTRL_IMM_ALU_EN is defined.
module opcode_class_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] instr_class,
    output logic       legal
);

    always_comb begin
        instr_class = CLS_NONE;
        legal       = 1'b0;
        case (opcode)
            OPC_R: begin
                instr_class = CLS_RTYPE;
                legal       = 1'b1;
            end
            OPC_LOAD: begin
                instr_class = CLS_LOAD;
                legal       = 1'b1;
            end
            OPC_STORE: begin
                instr_class = CLS_STORE;
                legal       = 1'b1;
            end
            OPC_BRANCH: begin
                instr_class = CLS_BRANCH;
                legal       = 1'b1;
            end
`ifdef MC_CTRL_IMM_ALU_EN
            OPC_OP_IMM: begin
                instr_class = CLS_OP_IMM;
                legal       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM (fetch/decode/execute/memory/writeback/halt).
// Optional I-type ALU support is enabled by defining MC_CTRL_IMM_ALU_EN.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal
);

    state_t       state_reg;
    state_t       state_next;
    logic [6:0]   opcode_reg;
    logic         illegal_reg;
    logic [6:0]   dec_opcode;
    logic [2:0]   cls_bits;
    logic         legal;
    instr_class_t cls;

    // The live IR opcode is only trusted during DECODE; afterwards the latched copy rules.
    assign dec_opcode = (state_reg == DECODE) ? opcode : opcode_reg;
    assign cls        = instr_class_t'(cls_bits);

    opcode_class_decode u_decode (
        .opcode      (dec_opcode),
        .instr_class (cls_bits),
        .legal       (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            opcode_reg  <= 7'd0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE)
                opcode_reg <= opcode;
            if (state_next == HALT)
                illegal_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;
        instr_done    = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_b  = SRCB_IMM;
                state_next = legal ? EXECUTE : HALT;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                case (cls)
                    CLS_RTYPE: begin
                        alu_op     = ALU_FUNCT;
                        state_next = WRITEBACK;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b  = SRCB_IMM;
                        state_next = MEM_ACCESS;
                    end
                    CLS_BRANCH: begin
                        alu_op        = ALU_SUB;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        instr_done    = 1'b1;
                        state_next    = FETCH;
                    end
`ifdef MC_CTRL_IMM_ALU_EN
                    CLS_OP_IMM: begin
                        alu_src_b  = SRCB_IMM;
                        alu_op     = ALU_FUNCT;
                        state_next = WRITEBACK;
                    end
`endif
                    default: state_next = HALT;
                endcase
            end
            MEM_ACCESS: begin
                i_or_d    = 1'b1;
                mem_read  = (cls == CLS_LOAD);
                mem_write = (cls != CLS_LOAD);
                if (mem_ready) begin
                    if (cls == CLS_LOAD) begin
                        state_next = WRITEBACK;
                    end else begin
                        instr_done = 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == CLS_LOAD);
                instr_done = 1'b1;
                state_next = FETCH;
            end
            HALT: state_next = HALT;
            default: state_next = FETCH;
        endcase

        // Reset must silence strobes at once, even in the middle of a memory access.
        if (!rst_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 1'b0;
            i_or_d        = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_RS2;
            alu_op        = ALU_ADD;
            instr_done    = 1'b0;
        end
    end

    assign illegal = illegal_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; outputs are packed into
// one 16-bit control word and compared per cycle against hand-computed values.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_source, i_or_d, ir_write;
    logic       mem_read, mem_write, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       instr_done, illegal;
    logic [15:0] ctl;

    int errors = 0;
    int checks = 0;

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal       (illegal)
    );

    // {pc_write, pc_write_cond, pc_source, i_or_d, ir_write, mem_read, mem_write,
    //  mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], instr_done, illegal}
    assign ctl = {pc_write, pc_write_cond, pc_source, i_or_d, ir_write, mem_read,
                  mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                  instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge; outputs are then sampled 1 ns later.
    task automatic cyc_in(input logic r, input logic [6:0] op, input logic rdy);
        @(negedge clk);
        rst_n     = r;
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        cyc_in(1'b0, 7'b0110011, 1'b1);
        checks++;
        if (ctl !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%h expected %h", ctl, 16'h0000);
        end
        cyc_in(1'b0, 7'b0110011, 1'b1);
        checks++;
        if (ctl !== 16'h0000) begin
            errors++;
            $display("FAIL reset_held: ctl=%h expected %h", ctl, 16'h0000);
        end
        $display("reset: ctl=%h", ctl);
    endtask

    task automatic test_rtype();
        logic [15:0] exp_ctl [5] = '{16'h8C10, 16'h0020, 16'h0048, 16'h0082, 16'h8C10};
        logic [6:0]  ops     [5] = '{7'b0110011, 7'b0110011, 7'b1111111, 7'b0000011, 7'b0110011};
        cyc_in(1'b0, 7'b0110011, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc_in(1'b1, ops[i], 1'b1);
            checks++;
            if (ctl !== exp_ctl[i]) begin
                errors++;
                $display("FAIL rtype cyc%0d: ctl=%h expected %h", i + 1, ctl, exp_ctl[i]);
            end
            $display("rtype cyc%0d: op=%b ctl=%h", i + 1, ops[i], ctl);
        end
    endtask

    task automatic test_lw_wait();
        logic        rdy     [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] exp_ctl [10] = '{16'h0410, 16'h0410, 16'h8C10, 16'h0020, 16'h0060,
                                      16'h1400, 16'h1400, 16'h1400, 16'h1400, 16'h0182};
        int irw_count = 0;
        cyc_in(1'b0, 7'b0000011, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc_in(1'b1, 7'b0000011, rdy[i]);
            if (ir_write) irw_count++;
            checks++;
            if (ctl !== exp_ctl[i]) begin
                errors++;
                $display("FAIL lw cyc%0d: ctl=%h expected %h", i + 1, ctl, exp_ctl[i]);
            end
            $display("lw cyc%0d: rdy=%b ctl=%h", i + 1, rdy[i], ctl);
        end
        checks++;
        if (irw_count !== 1) begin
            errors++;
            $display("FAIL lw_ir_write_count: got %0d expected 1", irw_count);
        end
    endtask

    task automatic test_sw_reset();
        logic        rdy     [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] exp_ctl [9] = '{16'h8C10, 16'h0020, 16'h0060, 16'h1200, 16'h1202,
                                     16'h8C10, 16'h0020, 16'h0060, 16'h1200};
        cyc_in(1'b0, 7'b0100011, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc_in(1'b1, 7'b0100011, rdy[i]);
            checks++;
            if (ctl !== exp_ctl[i]) begin
                errors++;
                $display("FAIL sw cyc%0d: ctl=%h expected %h", i + 1, ctl, exp_ctl[i]);
            end
            $display("sw cyc%0d: rdy=%b ctl=%h", i + 1, rdy[i], ctl);
        end
        // Assert reset between clock edges while the store is still waiting.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || ctl !== 16'h0000) begin
            errors++;
            $display("FAIL sw_async_reset: ctl=%h expected %h", ctl, 16'h0000);
        end
        $display("sw async reset: ctl=%h", ctl);
        cyc_in(1'b0, 7'b0100011, 1'b0);
        cyc_in(1'b1, 7'b0100011, 1'b1);
        checks++;
        if (ctl !== 16'h8C10) begin
            errors++;
            $display("FAIL sw_after_reset: ctl=%h expected %h", ctl, 16'h8C10);
        end
        $display("sw after reset: ctl=%h", ctl);
    endtask

    task automatic test_beq();
        logic [15:0] exp_ctl [4] = '{16'h8C10, 16'h0020, 16'h6046, 16'h8C10};
        cyc_in(1'b0, 7'b1100011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc_in(1'b1, 7'b1100011, 1'b1);
            checks++;
            if (ctl !== exp_ctl[i]) begin
                errors++;
                $display("FAIL beq cyc%0d: ctl=%h expected %h", i + 1, ctl, exp_ctl[i]);
            end
            $display("beq cyc%0d: ctl=%h", i + 1, ctl);
        end
    endtask

    task automatic test_illegal();
        int bad = 0;
        cyc_in(1'b0, 7'b1111111, 1'b1);
        cyc_in(1'b1, 7'b1111111, 1'b1);
        checks++;
        if (ctl !== 16'h8C10) begin
            errors++;
            $display("FAIL illegal_fetch: ctl=%h expected %h", ctl, 16'h8C10);
        end
        cyc_in(1'b1, 7'b1111111, 1'b1);
        checks++;
        if (ctl !== 16'h0020) begin
            errors++;
            $display("FAIL illegal_decode: ctl=%h expected %h", ctl, 16'h0020);
        end
        for (int i = 0; i < 20; i++) begin
            cyc_in(1'b1, (i % 2 == 0) ? 7'b0110011 : 7'b0000011, i[0]);
            if (ctl !== 16'h0001) begin
                bad++;
                $display("FAIL halt cyc%0d: ctl=%h expected %h", i, ctl, 16'h0001);
            end
        end
        checks++;
        if (bad != 0) errors++;
        $display("illegal: halt cycles with wrong outputs=%0d", bad);
        cyc_in(1'b0, 7'b1111111, 1'b1);
        checks++;
        if (ctl !== 16'h0000) begin
            errors++;
            $display("FAIL illegal_clear: ctl=%h expected %h", ctl, 16'h0000);
        end
        cyc_in(1'b1, 7'b1111111, 1'b1);
        checks++;
        if (ctl !== 16'h8C10) begin
            errors++;
            $display("FAIL illegal_refetch: ctl=%h expected %h", ctl, 16'h8C10);
        end
    endtask

    task automatic test_op_imm();
`ifdef MC_CTRL_IMM_ALU_EN
        logic [15:0] exp_ctl [5] = '{16'h8C10, 16'h0020, 16'h0068, 16'h0082, 16'h8C10};
`else
        logic [15:0] exp_ctl [5] = '{16'h8C10, 16'h0020, 16'h0001, 16'h0001, 16'h0001};
`endif
        cyc_in(1'b0, 7'b0010011, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc_in(1'b1, 7'b0010011, 1'b1);
            checks++;
            if (ctl !== exp_ctl[i]) begin
                errors++;
                $display("FAIL op_imm cyc%0d: ctl=%h expected %h", i + 1, ctl, exp_ctl[i]);
            end
            $display("op_imm cyc%0d: ctl=%h", i + 1, ctl);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_reset();
        test_beq();
        test_illegal();
        test_op_imm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            $display("FAIL mem_strobe_overlap: mem_read=%b mem_write=%b required not both", mem_read, mem_write);
            errors++;
        end
    end

endmodule
